ms_slave_feeder: RTL and testbench

MS_SLAVE_FEEDER -- requirements
Module: ms_slave_feeder

---
 rtl/ms_slave_feeder_pkg.sv | 20 ++
 rtl/ms_slave_feeder_fifo.sv | 76 +++++++
 rtl/ms_slave_feeder.sv | 125 ++++++++++++
 tb/tb_ms_slave_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ms_slave_feeder_pkg.sv
// ms_feeder_types: shared types and default constants for the slave feeder.
//   feed_state_e   : output sequencer states (idle, emit a word, enforced gap)
//   DEFAULT_DEPTH  : default FIFO depth in entries
//   DEFAULT_GAP    : default idle cycles between output pulses
//   DATA_W/LEVEL_W/GAP_W : data, occupancy and gap-counter widths
package ms_feeder_types;

    typedef enum logic [1:0] {
        FEED_IDLE = 2'd0,
        FEED_EMIT = 2'd1,
        FEED_GAP  = 2'd2
    } feed_state_e;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_GAP   = 1;
    localparam int DATA_W        = 32;
    localparam int LEVEL_W       = 5;
    localparam int GAP_W         = 4;

endpackage

// File: rtl/ms_slave_feeder_fifo.sv
// ms_feeder_fifo: circular FIFO storage for the slave feeder.
//   clk, rst : clock and synchronous active-low reset
//   push     : write din at the tail (ignored when full)
//   pop      : advance the head (ignored when empty)
//   din      : write data
//   dout     : data at the head, valid while level > 0
//   level    : occupancy, 0..DEPTH
module ms_feeder_fifo
    import ms_feeder_types::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout,
    output logic [LEVEL_W-1:0] level
);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]  mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [LEVEL_W-1:0] level_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Qualify requests so the occupancy can never leave 0..DEPTH.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (level_r < LEVEL_W'(DEPTH)) begin
            push_ok_s = push;
        end else begin
            push_ok_s = 1'b0;
        end
        if (level_r != {LEVEL_W{1'b0}}) begin
            pop_ok_s = pop;
        end else begin
            pop_ok_s = 1'b0;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst && push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LEVEL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_r + {{(LEVEL_W-1){1'b0}}, push_ok_s}
                               - {{(LEVEL_W-1){1'b0}}, pop_ok_s};
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/ms_slave_feeder.sv
// ms_slave_feeder: buffers words from an upstream master and replays them
// to a downstream slave as single-cycle pulses separated by GAP idle cycles.
//   clk, rst    : clock and synchronous active-low reset
//   m_in        : 32-bit signed data from upstream
//   m_in_sync   : upstream data-valid
//   m_in_notify : ready to upstream (FIFO not full, not in reset)
//   s_out       : last emitted word, held between pulses
//   s_out_sync  : one-cycle pulse marking a new s_out
//   level       : FIFO occupancy
module ms_slave_feeder
    import ms_feeder_types::*;
#(
    parameter int GAP   = DEFAULT_GAP,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  m_in,
    input  logic               m_in_sync,
    output logic               m_in_notify,
    output logic [DATA_W-1:0]  s_out,
    output logic               s_out_sync,
    output logic [LEVEL_W-1:0] level
);

    feed_state_e        state_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [DATA_W-1:0]  s_out_r;
    logic               s_out_sync_r;
    logic               notify_s;
    logic               push_s;
    logic               pop_s;
    logic [DATA_W-1:0]  head_s;
    logic [LEVEL_W-1:0] level_s;
    logic [LEVEL_W-1:0] level_after_pop_s;

    ms_feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (m_in),
        .dout  (head_s),
        .level (level_s)
    );

    // Handshake and pop decode. Ready depends only on the registered level,
    // so a pop in the same cycle never opens a slot for a push when full.
    always_comb begin
        notify_s = 1'b0;
        pop_s    = 1'b0;
        if (rst && (level_s < LEVEL_W'(DEPTH))) begin
            notify_s = 1'b1;
        end else begin
            notify_s = 1'b0;
        end
        if ((state_r == FEED_EMIT) && (level_s != {LEVEL_W{1'b0}})) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        push_s            = m_in_sync & notify_s;
        level_after_pop_s = level_s + {{(LEVEL_W-1){1'b0}}, push_s}
                                    - {{(LEVEL_W-1){1'b0}}, pop_s};
    end

    // Output sequencer. The head is popped during FEED_EMIT and captured into
    // s_out at the end of that cycle, giving a two-cycle push-to-pulse latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= FEED_IDLE;
            gap_cnt_r    <= {GAP_W{1'b0}};
            s_out_r      <= {DATA_W{1'b0}};
            s_out_sync_r <= 1'b0;
        end else begin
            s_out_sync_r <= 1'b0;
            case (state_r)
                FEED_IDLE: begin
                    if (level_s != {LEVEL_W{1'b0}}) begin
                        state_r <= FEED_EMIT;
                    end else begin
                        state_r <= FEED_IDLE;
                    end
                end
                FEED_EMIT: begin
                    if (pop_s) begin
                        s_out_r      <= head_s;
                        s_out_sync_r <= 1'b1;
                    end
                    if (GAP > 0) begin
                        state_r   <= FEED_GAP;
                        gap_cnt_r <= GAP_W'(GAP - 1);
                    end else if (level_after_pop_s != {LEVEL_W{1'b0}}) begin
                        state_r <= FEED_EMIT;
                    end else begin
                        state_r <= FEED_IDLE;
                    end
                end
                FEED_GAP: begin
                    if (gap_cnt_r == {GAP_W{1'b0}}) begin
                        if (level_s != {LEVEL_W{1'b0}}) begin
                            state_r <= FEED_EMIT;
                        end else begin
                            state_r <= FEED_IDLE;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
                default: begin
                    state_r   <= FEED_IDLE;
                    gap_cnt_r <= {GAP_W{1'b0}};
                end
            endcase
        end
    end

    assign m_in_notify = notify_s;
    assign s_out       = s_out_r;
    assign s_out_sync  = s_out_sync_r;
    assign level       = level_s;

endmodule

// File: tb/tb_ms_slave_feeder.sv
// Self-checking bench: instance A runs with GAP=1, instance B with GAP=0,
// both DEPTH=4. Expected words are queued when a push is accepted and
// compared when the matching s_out_sync pulse appears.
module tb_ms_slave_feeder;

    logic        clk;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic        a_sync, b_sync;
    logic        a_notify, b_notify;
    logic [31:0] a_out, b_out;
    logic        a_osync, b_osync;
    logic [4:0]  a_level, b_level;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          pa_cyc[$];
    int          pb_cnt;
    int          cyc;
    int          errors;
    int          checks;
    int          a_waits;
    bit          a_full_seen;
    logic [31:0] a_prev_out, b_prev_out;

    ms_slave_feeder #(.GAP(1), .DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .m_in(a_in), .m_in_sync(a_sync),
        .m_in_notify(a_notify), .s_out(a_out), .s_out_sync(a_osync), .level(a_level)
    );

    ms_slave_feeder #(.GAP(0), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .m_in(b_in), .m_in_sync(b_sync),
        .m_in_notify(b_notify), .s_out(b_out), .s_out_sync(b_osync), .level(b_level)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            check_value("a_notify_lvl", 32'(a_notify), 32'(a_level < 5'd4));
            check_value("b_notify_lvl", 32'(b_notify), 32'(b_level < 5'd4));
            if (!a_osync) check_value("a_hold", a_out, a_prev_out);
            if (!b_osync) check_value("b_hold", b_out, b_prev_out);
        end else begin
            check_value("a_notify_rst", 32'(a_notify), 32'd0);
            check_value("b_notify_rst", 32'(b_notify), 32'd0);
        end
        if (a_level == 5'd4) a_full_seen = 1'b1;
        if (a_osync) begin
            pa_cyc.push_back(cyc);
            if (qa.size() == 0) check_value("a_unexpected_pulse", a_out, 32'hDEAD_BEEF);
            else check_value("a_data", a_out, qa.pop_front());
        end
        if (b_osync) begin
            pb_cnt++;
            if (qb.size() == 0) check_value("b_unexpected_pulse", b_out, 32'hDEAD_BEEF);
            else check_value("b_data", b_out, qb.pop_front());
        end
        a_prev_out = a_out;
        b_prev_out = b_out;
    end

    // Offer v to instance A and wait (bounded) until it is accepted.
    task automatic push_a(input logic [31:0] v, output int acc_edge);
        int n;
        n = 0;
        acc_edge = -1;
        @(negedge clk);
        a_in   = v;
        a_sync = 1'b1;
        while (!a_notify && n < 100) begin
            @(negedge clk);
            n++;
        end
        a_waits += n;
        if (!a_notify) begin
            check_value("a_push_bound", 32'(a_notify), 32'd1);
        end else begin
            qa.push_back(v);
            acc_edge = cyc + 1;
            @(posedge clk);
        end
    endtask

    // Offer v to instance B and wait (bounded) until it is accepted.
    task automatic push_b(input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        b_in   = v;
        b_sync = 1'b1;
        while (!b_notify && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!b_notify) begin
            check_value("b_push_bound", 32'(b_notify), 32'd1);
        end else begin
            qb.push_back(v);
            @(posedge clk);
        end
    endtask

    // Bounded wait for both scoreboards to empty.
    task automatic wait_drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("drain_a", 32'(qa.size()), 32'd0);
        check_value("drain_b", 32'(qb.size()), 32'd0);
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, e;
        errors = 0; checks = 0; cyc = 0; pb_cnt = 0; a_waits = 0;
        a_full_seen = 1'b0;
        rst = 1'b0;
        a_in = 32'd0; b_in = 32'd0; a_sync = 1'b0; b_sync = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_a_level", 32'(a_level), 32'd0);
        check_value("rst_a_out", a_out, 32'd0);
        check_value("rst_a_osync", 32'(a_osync), 32'd0);
        check_value("rst_a_notify", 32'(a_notify), 32'd0);
        check_value("rst_b_level", 32'(b_level), 32'd0);
        rst = 1'b1;
        #1;
        check_value("rel_a_notify", 32'(a_notify), 32'd1);

        // Single word latency: pulse two edges after the push edge
        pa_cyc.delete();
        push_a(32'd7, e0);
        @(negedge clk);
        a_sync = 1'b0;
        check_value("lat_e0_osync", 32'(a_osync), 32'd0);
        check_value("lat_e0_level", 32'(a_level), 32'd1);
        @(negedge clk);
        check_value("lat_e1_osync", 32'(a_osync), 32'd0);
        @(negedge clk);
        check_value("lat_e2_osync", 32'(a_osync), 32'd1);
        check_value("lat_e2_out", a_out, 32'd7);
        check_value("lat_e2_level", 32'(a_level), 32'd0);

        // GAP=1: back-to-back 1,2,3 -> pulses every second cycle
        repeat (3) @(negedge clk);
        pa_cyc.delete();
        push_a(32'd1, e0);
        push_a(32'd2, e);
        push_a(32'd3, e);
        @(negedge clk);
        a_sync = 1'b0;
        repeat (8) @(negedge clk);
        check_value("gap1_pulse_count", 32'(pa_cyc.size()), 32'd3);
        if (pa_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_value("gap1_pulse_cycle", 32'(pa_cyc[i]), 32'(e0 + 2 + 2 * i));
            end
        end

        // Fill A to full, then 99 must wait and arrive after the others
        for (int i = 11; i <= 18; i++) push_a(32'(i), e);
        push_a(32'd99, e);
        @(negedge clk);
        a_sync = 1'b0;
        wait_drain();
        check_value("a_full_seen", 32'(a_full_seen), 32'd1);
        check_value("a_waited_when_full", 32'(a_waits > 0), 32'd1);

        // Reset during the gap after the first of 10,20
        repeat (3) @(negedge clk);
        pa_cyc.delete();
        push_a(32'd10, e0);
        push_a(32'd20, e);
        @(negedge clk);
        a_sync = 1'b0;
        @(negedge clk);
        check_value("gap_rst_pulse10", 32'(a_osync), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_value("gap_rst_level", 32'(a_level), 32'd0);
        check_value("gap_rst_out", a_out, 32'd0);
        check_value("gap_rst_osync", 32'(a_osync), 32'd0);
        check_value("gap_rst_pending", 32'(qa.size()), 32'd1);
        qa.delete();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check_value("gap_rst_pulses", 32'(pa_cyc.size()), 32'd1);

        // GAP=0: five words then twenty random words streamed continuously
        pb_cnt = 0;
        for (int i = 0; i < 5; i++) push_b(32'(100 + i));
        for (int i = 0; i < 20; i++) push_b($urandom);
        @(negedge clk);
        b_sync = 1'b0;
        wait_drain();
        check_value("b_pulse_count", 32'(pb_cnt), 32'd25);
        check_value("b_final_level", 32'(b_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
